// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential floating-point divider.
//   EXP_W / MAN_W : binary32 exponent and mantissa field widths
//   BIAS          : exponent bias
//   EXP_INF       : all-ones exponent used for the infinity pattern
//   state_t       : divider control states
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [7:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem      [24:0] in  : partial remainder (always < 2*divisor)
//   divisor  [23:0] in  : normalised divisor {1,m2}
//   rem_next [24:0] out : remainder for the next step, already shifted left
//   q_bit           out : quotient bit produced by this step
module fdiv_step (
  input  logic [24:0] rem,
  input  logic [23:0] divisor,
  output logic [24:0] rem_next,
  output logic        q_bit
);

  logic [23:0] diff;

  // The remainder after a successful subtract is below the divisor, so it
  // fits in 24 bits and only the low 24 bits of the difference are needed.
  always_comb begin
    q_bit    = (rem >= {1'b0, divisor});
    diff     = rem[23:0] - divisor;
    rem_next = q_bit ? {diff, 1'b0} : {rem[23:0], 1'b0};
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 binary32 divider (y = x1 / x2), one quotient bit per
// cycle, with a fixed latency of K+2 cycles from input to output transfer.
// Optional macro FDIV_ROUND_EN: computes one extra guard bit (K=26) and
// rounds to nearest even; without it (K=25) the mantissa is truncated.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   x1, x2     [31:0]   : dividend / divisor
//   in_valid, in_ready  : input handshake (in_ready only in IDLE)
//   y          [31:0]   : quotient
//   ovf                 : overflow to infinity or division by zero
//   out_valid, out_ready: output handshake
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

`ifdef FDIV_ROUND_EN
  localparam int K = 26;
`else
  localparam int K = 25;
`endif
  localparam logic [4:0] K_LAST = 5'(K);

  state_t             state, next_state;
  logic               ys;
  logic [EXP_W-1:0]   e1, e2;
  logic [24:0]        rem, rem_next;
  logic [23:0]        divisor;
  logic [K-1:0]       quo;
  logic [4:0]         cnt;
  logic               q_bit;
  logic signed [9:0]  ye;
  logic [MAN_W-1:0]   mant;
  logic [31:0]        res_y;
  logic               res_ovf;
`ifdef FDIV_ROUND_EN
  logic               guard, sticky, round_up;
  logic [MAN_W:0]     mant_rnd;
`endif

  fdiv_step u_step (
    .rem      (rem),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // CALC holds one extra cycle once the counter reaches K so that every
  // operation, special cases included, sees the same K+2 latency.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC: if (cnt == K_LAST) next_state = NORM;
      NORM: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ys      <= 1'b0;
      e1      <= '0;
      e2      <= '0;
      rem     <= '0;
      divisor <= '0;
      quo     <= '0;
      cnt     <= '0;
      y       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ys      <= x1[31] ^ x2[31];
          e1      <= x1[MAN_W +: EXP_W];
          e2      <= x2[MAN_W +: EXP_W];
          rem     <= {2'b01, x1[MAN_W-1:0]};
          divisor <= {1'b1, x2[MAN_W-1:0]};
          quo     <= '0;
          cnt     <= '0;
        end
        CALC: if (cnt != K_LAST) begin
          rem <= rem_next;
          quo <= {quo[K-2:0], q_bit};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          y   <= res_y;
          ovf <= res_ovf;
        end
        default: ;
      endcase
    end
  end

  // Quotient of two [1,2) mantissas lies in (0.5,2): its MSB is the 2^0
  // bit, and a zero MSB means one left shift and one less exponent.
  always_comb begin
    ye = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(BIAS));
    if (!quo[K-1]) ye = ye - 10'sd1;
    mant = quo[K-1] ? quo[K-2 -: MAN_W] : quo[K-3 -: MAN_W];
`ifdef FDIV_ROUND_EN
    guard    = quo[K-1] ? quo[K-25] : quo[K-26];
    sticky   = (quo[K-1] & quo[0]) | (rem != '0);
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + (MAN_W+1)'(round_up);
    mant     = mant_rnd[MAN_W-1:0];
    if (mant_rnd[MAN_W]) ye = ye + 10'sd1;
`endif
    res_y   = {ys, ye[EXP_W-1:0], mant};
    res_ovf = 1'b0;
    if (e2 == '0) begin
      res_y   = {ys, EXP_INF, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (e1 == '0) begin
      res_y = {ys, 31'b0};
    end else if (ye >= 10'sd255) begin
      res_y   = {ys, EXP_INF, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (ye <= 10'sd0) begin
      res_y = {ys, 31'b0};
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed testbench for fdiv_seq: latency, arithmetic results, special
// cases, backpressure and mid-operation reset.
module tb_fdiv_seq;

`ifdef FDIV_ROUND_EN
  localparam int K = 26;
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam int K = 25;
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  logic        clk, rst, in_valid, in_ready, ovf, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  int checks = 0;
  int failures = 0;
  int latency;
  logic sawValid;

  fdiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for in_ready, then performs one input transfer.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    checkOutput("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x1 = 32'h0;
    x2 = 32'h0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expY, input logic expOvf);
    int lat;
    applyStimulus(a, b);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(K + 2));
    checkOutput({tag, "_y"}, y, expY);
    checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, expOvf});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x1 = 32'h0;
    x2 = 32'h0;
    #12;
    checkOutput("reset_y", y, 32'h0);
    checkOutput("reset_ovf_valid", {30'b0, ovf, out_valid}, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed arithmetic vectors");
    runOp("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    runOp("one_by_three", 32'h3F800000, 32'h40400000, ONE_THIRD,    1'b0);
    runOp("div_zero_pos", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    runOp("div_zero_neg", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
    runOp("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1);
    runOp("overflow",     32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1);
    runOp("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
    runOp("zero_dividend",32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
    runOp("neg_six",      32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0);
    runOp("exp255_input", 32'h7F800000, 32'h40000000, 32'h7F000000, 1'b0);
    runOp("equal",        32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResult(latency);
    checkOutput("bp_latency", 32'(latency), 32'(K + 2));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp_hold_y", y, 32'h40400000);
      checkOutput("bp_hold_flags", {29'b0, out_valid, in_ready, ovf}, 32'b100);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_idle", {30'b0, in_ready, out_valid}, 32'b10);
    sawValid = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) sawValid = 1'b1;
    end
    checkOutput("bp_ignored_input", {31'b0, sawValid}, 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("midrst_y", y, 32'h0);
    checkOutput("midrst_flags", {30'b0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_valid", {31'b0, sawValid}, 32'd0);
    runOp("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
